id_control_unit: RTL and testbench
==================================

# id_control_unit

Instruction-decode control block of the 5-stage MIPS pipeline. Decodes the 32-bit instruction fetched in ID into datapath control signals. A NOP mux forces all controls to zero on hazard stalls or flushes, and the result is registered into the ID/EX control register. It also contains the IF-stage next-address select mux, which chooses between the sequential nPC and a jump/branch target address (TA).

## Interface
- No parameters.
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset; one clock.
- instruction  in  32  instruction word in ID.
- controlMux  in  1  1 = force NOP (all controls 0), 0 = pass decoded controls.
- nPC  in  9  sequential next PC.
- TA  in  32  target address.
- S  in  1  PC select: 1 = TA, 0 = nPC.
- Address  out  32  selected fetch address (combinational).
- ID_* outputs (combinational, raw decode):
  - ID_ALU_OP[3:0], ID_OP_H_S[2:0], ID_DESTINATION_REGISTER[1:0], ID_MEM_SIZE[1:0]
  - ID_LOAD_INSTR, ID_RF_ENABLE, ID_HI_ENABLE, ID_LO_ENABLE, ID_PC_PLUS8_INSTR, ID_UB_INSTR, ID_JALR_JR_INSTR, ID_MEM_ENABLE, ID_MEM_READWRITE, ID_MEM_SIGNE
- OUT_ID_* outputs: same set and widths after the NOP mux (combinational).
- EX_* outputs: same set and widths, registered OUT_ID_* values.

## Operation
- Address = S ? TA : {23'b0, nPC}.
- OUT_ID_x = controlMux ? 0 : ID_x, for every signal.
- EX_x is loaded from OUT_ID_x on every rising Clk edge.
- Encodings:
  - ALU_OP: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 pass-B, 12 pass-A.
  - OP_H_S (operand-2 handler): 000 rt, 001 sign-extended imm16, 010 zero-extended imm16, 011 imm16<<16, 100 shamt, 101 HI, 110 LO, 111 PC+8.
  - DESTINATION_REGISTER: 00 rd, 01 rt, 10 r31.
  - MEM_SIZE: 00 byte, 01 half, 10 word.
  - MEM_READWRITE: 1 = write.
- R-type (op 0):
  - ADD/ADDU → 0, SUB/SUBU → 1, AND 2, OR 3, XOR 4, NOR 5, SLT 9, SLTU 10, all with OP_H_S 000.
  - SLL/SRL/SRA use ALU 6/7/8 with OP_H_S 100. SLLV/SRLV/SRAV use the same ALU codes with OP_H_S 000.
  - All of the above: RF_ENABLE = 1, DEST 00.
- HI/LO moves:
  - MFHI/MFLO: ALU 11, OP_H_S 101/110, RF_ENABLE = 1, DEST 00.
  - MTHI/MTLO: ALU 12, HI_ENABLE or LO_ENABLE = 1, RF_ENABLE = 0.
- JR: JALR_JR_INSTR = 1, RF_ENABLE = 0.
- JALR: JALR_JR_INSTR = 1, PC_PLUS8_INSTR = 1, RF_ENABLE = 1, DEST 00, ALU 11, OP_H_S 111.
- Immediates (RF_ENABLE = 1, DEST 01):
  - ADDI/ADDIU: ALU 0, OP_H_S 001.
  - SLTI/SLTIU: ALU 9/10, OP_H_S 001.
  - ANDI/ORI/XORI: ALU 2/3/4, OP_H_S 010.
  - LUI: ALU 11, OP_H_S 011.
- Loads LB/LBU/LH/LHU/LW:
  - LOAD_INSTR = 1, RF_ENABLE = 1, DEST 01, ALU 0, OP_H_S 001, MEM_ENABLE = 1, READWRITE = 0.
  - Sizes: byte/byte/half/half/word. MEM_SIGNE = 1 for LB and LH only.
- Stores SB/SH/SW: MEM_ENABLE = 1, READWRITE = 1, ALU 0, OP_H_S 001, sizes byte/half/word, RF_ENABLE = 0.
- Conditional branches BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ: ALU 1, OP_H_S 000, no writes.
- Branch-and-link BLTZAL/BGEZAL: additionally PC_PLUS8_INSTR = 1, RF_ENABLE = 1, DEST 10, ALU 11, OP_H_S 111.
- J: UB_INSTR = 1.
- JAL: UB_INSTR = 1, PC_PLUS8_INSTR = 1, RF_ENABLE = 1, DEST 10, ALU 11, OP_H_S 111.
- Instruction 32'h00000000 and any unlisted opcode/funct decode to all-zero controls.

## Timing
- Decode, NOP mux and Address are purely combinational, with zero-cycle latency.
- EX_* have one-cycle latency from instruction/controlMux.
- Reset high at a rising edge: every EX_* output is 0 (NOP).
- Reset has no effect on combinational outputs.
- Reset mid-stream discards the instruction being registered that cycle.
- controlMux and Reset both active: EX_* = 0.
- S toggles take effect on Address immediately, independent of Clk.

## Test plan
- Reset held 1 for one edge, instruction = LW (8C220004) → EX_* all 0. Next edge with Reset 0 → EX_LOAD_INSTR = 1, EX_MEM_SIZE = 10, EX_DESTINATION_REGISTER = 01.
- instruction = ADD (00430820), controlMux 0 → ID_ALU_OP = 0, ID_RF_ENABLE = 1, DEST = 00. Same with controlMux 1 → OUT_ID_* all 0; after the edge, EX_* all 0.
- SB (A0220003) → MEM_ENABLE = 1, READWRITE = 1, SIZE = 00, RF_ENABLE = 0. LB (80220003) → MEM_SIGNE = 1. LBU (90220003) → MEM_SIGNE = 0.
- JAL (0C000010) → UB = 1, PC_PLUS8 = 1, DEST = 10. JR (03E00008) → JALR_JR = 1, RF_ENABLE = 0.
- nPC = 9'h1FC, TA = 32'h00000040: S = 0 → Address = 32'h000001FC; S = 1 → Address = 32'h00000040.
- instruction 0 and undefined opcode 6'h3F → all controls 0.

Source files
------------

// File: rtl/id_control_unit.sv
// ID-stage control decode for the 5-stage MIPS pipeline: raw decode, NOP mux for
// stalls/flushes, the ID/EX control register, and the IF next-fetch address mux.
module id_control_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] instruction,
    input  logic        controlMux,
    input  logic [8:0]  nPC,
    input  logic [31:0] TA,
    input  logic        S,
    output logic [31:0] Address,

    output logic [3:0]  ID_ALU_OP,
    output logic [2:0]  ID_OP_H_S,
    output logic [1:0]  ID_DESTINATION_REGISTER,
    output logic [1:0]  ID_MEM_SIZE,
    output logic        ID_LOAD_INSTR,
    output logic        ID_RF_ENABLE,
    output logic        ID_HI_ENABLE,
    output logic        ID_LO_ENABLE,
    output logic        ID_PC_PLUS8_INSTR,
    output logic        ID_UB_INSTR,
    output logic        ID_JALR_JR_INSTR,
    output logic        ID_MEM_ENABLE,
    output logic        ID_MEM_READWRITE,
    output logic        ID_MEM_SIGNE,

    output logic [3:0]  OUT_ID_ALU_OP,
    output logic [2:0]  OUT_ID_OP_H_S,
    output logic [1:0]  OUT_ID_DESTINATION_REGISTER,
    output logic [1:0]  OUT_ID_MEM_SIZE,
    output logic        OUT_ID_LOAD_INSTR,
    output logic        OUT_ID_RF_ENABLE,
    output logic        OUT_ID_HI_ENABLE,
    output logic        OUT_ID_LO_ENABLE,
    output logic        OUT_ID_PC_PLUS8_INSTR,
    output logic        OUT_ID_UB_INSTR,
    output logic        OUT_ID_JALR_JR_INSTR,
    output logic        OUT_ID_MEM_ENABLE,
    output logic        OUT_ID_MEM_READWRITE,
    output logic        OUT_ID_MEM_SIGNE,

    output logic [3:0]  EX_ALU_OP,
    output logic [2:0]  EX_OP_H_S,
    output logic [1:0]  EX_DESTINATION_REGISTER,
    output logic [1:0]  EX_MEM_SIZE,
    output logic        EX_LOAD_INSTR,
    output logic        EX_RF_ENABLE,
    output logic        EX_HI_ENABLE,
    output logic        EX_LO_ENABLE,
    output logic        EX_PC_PLUS8_INSTR,
    output logic        EX_UB_INSTR,
    output logic        EX_JALR_JR_INSTR,
    output logic        EX_MEM_ENABLE,
    output logic        EX_MEM_READWRITE,
    output logic        EX_MEM_SIGNE
);

    typedef struct packed {
        logic [3:0] alu_op;
        logic [2:0] op_h_s;
        logic [1:0] dest;
        logic [1:0] mem_size;
        logic       load;
        logic       rf_en;
        logic       hi_en;
        logic       lo_en;
        logic       pc8;
        logic       ub;
        logic       jalr_jr;
        logic       mem_en;
        logic       mem_rw;
        logic       mem_signe;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = ctrl_t'(21'd0);

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_NOR   = 4'd5;
    localparam logic [3:0] ALU_SLL   = 4'd6;
    localparam logic [3:0] ALU_SRL   = 4'd7;
    localparam logic [3:0] ALU_SRA   = 4'd8;
    localparam logic [3:0] ALU_SLT   = 4'd9;
    localparam logic [3:0] ALU_SLTU  = 4'd10;
    localparam logic [3:0] ALU_PASSB = 4'd11;
    localparam logic [3:0] ALU_PASSA = 4'd12;

    localparam logic [2:0] OPH_RT    = 3'b000;
    localparam logic [2:0] OPH_SIMM  = 3'b001;
    localparam logic [2:0] OPH_ZIMM  = 3'b010;
    localparam logic [2:0] OPH_LUI   = 3'b011;
    localparam logic [2:0] OPH_SHAMT = 3'b100;
    localparam logic [2:0] OPH_HI    = 3'b101;
    localparam logic [2:0] OPH_LO    = 3'b110;
    localparam logic [2:0] OPH_PC8   = 3'b111;

    localparam logic [1:0] DST_RD  = 2'b00;
    localparam logic [1:0] DST_RT  = 2'b01;
    localparam logic [1:0] DST_R31 = 2'b10;

    localparam logic [1:0] MS_BYTE = 2'b00;
    localparam logic [1:0] MS_HALF = 2'b01;
    localparam logic [1:0] MS_WORD = 2'b10;

    logic [5:0] opcode_s;
    logic [5:0] funct_s;
    logic [4:0] rt_s;
    ctrl_t      id_s;
    ctrl_t      out_id_d;
    ctrl_t      ex_q;

    assign opcode_s = instruction[31:26];
    assign funct_s  = instruction[5:0];
    assign rt_s     = instruction[20:16];

    // Raw decode; the all-zero word is the canonical NOP even though it encodes SLL.
    always_comb begin
        id_s = CTRL_NOP;
        if (instruction == 32'h0000_0000) begin
            id_s = CTRL_NOP;
        end else begin
            case (opcode_s)
                6'h00: begin
                    case (funct_s)
                        6'h00, 6'h02, 6'h03: begin
                            id_s.alu_op = (funct_s == 6'h00) ? ALU_SLL :
                                          (funct_s == 6'h02) ? ALU_SRL : ALU_SRA;
                            id_s.op_h_s = OPH_SHAMT;
                            id_s.rf_en  = 1'b1;
                            id_s.dest   = DST_RD;
                        end
                        6'h04, 6'h06, 6'h07: begin
                            id_s.alu_op = (funct_s == 6'h04) ? ALU_SLL :
                                          (funct_s == 6'h06) ? ALU_SRL : ALU_SRA;
                            id_s.op_h_s = OPH_RT;
                            id_s.rf_en  = 1'b1;
                            id_s.dest   = DST_RD;
                        end
                        6'h08: begin
                            id_s.jalr_jr = 1'b1;
                        end
                        6'h09: begin
                            id_s.jalr_jr = 1'b1;
                            id_s.pc8     = 1'b1;
                            id_s.rf_en   = 1'b1;
                            id_s.dest    = DST_RD;
                            id_s.alu_op  = ALU_PASSB;
                            id_s.op_h_s  = OPH_PC8;
                        end
                        6'h10, 6'h12: begin
                            id_s.alu_op = ALU_PASSB;
                            id_s.op_h_s = (funct_s == 6'h10) ? OPH_HI : OPH_LO;
                            id_s.rf_en  = 1'b1;
                            id_s.dest   = DST_RD;
                        end
                        6'h11: begin
                            id_s.alu_op = ALU_PASSA;
                            id_s.hi_en  = 1'b1;
                        end
                        6'h13: begin
                            id_s.alu_op = ALU_PASSA;
                            id_s.lo_en  = 1'b1;
                        end
                        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
                            case (funct_s)
                                6'h20, 6'h21: id_s.alu_op = ALU_ADD;
                                6'h22, 6'h23: id_s.alu_op = ALU_SUB;
                                6'h24:        id_s.alu_op = ALU_AND;
                                6'h25:        id_s.alu_op = ALU_OR;
                                6'h26:        id_s.alu_op = ALU_XOR;
                                6'h27:        id_s.alu_op = ALU_NOR;
                                6'h2A:        id_s.alu_op = ALU_SLT;
                                default:      id_s.alu_op = ALU_SLTU;
                            endcase
                            id_s.op_h_s = OPH_RT;
                            id_s.rf_en  = 1'b1;
                            id_s.dest   = DST_RD;
                        end
                        default: id_s = CTRL_NOP;
                    endcase
                end
                // REGIMM: the rt field selects the branch flavour
                6'h01: begin
                    case (rt_s)
                        5'd0, 5'd1: begin
                            id_s.alu_op = ALU_SUB;
                            id_s.op_h_s = OPH_RT;
                        end
                        5'd16, 5'd17: begin
                            id_s.pc8    = 1'b1;
                            id_s.rf_en  = 1'b1;
                            id_s.dest   = DST_R31;
                            id_s.alu_op = ALU_PASSB;
                            id_s.op_h_s = OPH_PC8;
                        end
                        default: id_s = CTRL_NOP;
                    endcase
                end
                6'h02: begin
                    id_s.ub = 1'b1;
                end
                6'h03: begin
                    id_s.ub     = 1'b1;
                    id_s.pc8    = 1'b1;
                    id_s.rf_en  = 1'b1;
                    id_s.dest   = DST_R31;
                    id_s.alu_op = ALU_PASSB;
                    id_s.op_h_s = OPH_PC8;
                end
                6'h04, 6'h05, 6'h06, 6'h07: begin
                    id_s.alu_op = ALU_SUB;
                    id_s.op_h_s = OPH_RT;
                end
                6'h08, 6'h09, 6'h0A, 6'h0B: begin
                    id_s.alu_op = (opcode_s == 6'h0A) ? ALU_SLT :
                                  (opcode_s == 6'h0B) ? ALU_SLTU : ALU_ADD;
                    id_s.op_h_s = OPH_SIMM;
                    id_s.rf_en  = 1'b1;
                    id_s.dest   = DST_RT;
                end
                6'h0C, 6'h0D, 6'h0E: begin
                    id_s.alu_op = (opcode_s == 6'h0C) ? ALU_AND :
                                  (opcode_s == 6'h0D) ? ALU_OR : ALU_XOR;
                    id_s.op_h_s = OPH_ZIMM;
                    id_s.rf_en  = 1'b1;
                    id_s.dest   = DST_RT;
                end
                6'h0F: begin
                    id_s.alu_op = ALU_PASSB;
                    id_s.op_h_s = OPH_LUI;
                    id_s.rf_en  = 1'b1;
                    id_s.dest   = DST_RT;
                end
                // Loads: LB 20, LH 21, LW 23, LBU 24, LHU 25
                6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                    id_s.load      = 1'b1;
                    id_s.rf_en     = 1'b1;
                    id_s.dest      = DST_RT;
                    id_s.alu_op    = ALU_ADD;
                    id_s.op_h_s    = OPH_SIMM;
                    id_s.mem_en    = 1'b1;
                    id_s.mem_rw    = 1'b0;
                    id_s.mem_size  = (opcode_s == 6'h23) ? MS_WORD :
                                     (opcode_s[0] == 1'b1) ? MS_HALF : MS_BYTE;
                    id_s.mem_signe = (opcode_s == 6'h20) || (opcode_s == 6'h21);
                end
                6'h28, 6'h29, 6'h2B: begin
                    id_s.mem_en   = 1'b1;
                    id_s.mem_rw   = 1'b1;
                    id_s.alu_op   = ALU_ADD;
                    id_s.op_h_s   = OPH_SIMM;
                    id_s.mem_size = (opcode_s == 6'h28) ? MS_BYTE :
                                    (opcode_s == 6'h29) ? MS_HALF : MS_WORD;
                end
                default: id_s = CTRL_NOP;
            endcase
        end
    end

    // NOP mux: a stall or flush replaces the decoded controls with a bubble.
    always_comb begin
        if (controlMux) begin
            out_id_d = CTRL_NOP;
        end else begin
            out_id_d = id_s;
        end
    end

    // ID/EX control register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_q <= CTRL_NOP;
        end else begin
            ex_q <= out_id_d;
        end
    end

    // IF next-fetch address select.
    always_comb begin
        if (S) begin
            Address = TA;
        end else begin
            Address = {23'd0, nPC};
        end
    end

    assign {ID_ALU_OP, ID_OP_H_S, ID_DESTINATION_REGISTER, ID_MEM_SIZE, ID_LOAD_INSTR,
            ID_RF_ENABLE, ID_HI_ENABLE, ID_LO_ENABLE, ID_PC_PLUS8_INSTR, ID_UB_INSTR,
            ID_JALR_JR_INSTR, ID_MEM_ENABLE, ID_MEM_READWRITE, ID_MEM_SIGNE} = id_s;

    assign {OUT_ID_ALU_OP, OUT_ID_OP_H_S, OUT_ID_DESTINATION_REGISTER, OUT_ID_MEM_SIZE,
            OUT_ID_LOAD_INSTR, OUT_ID_RF_ENABLE, OUT_ID_HI_ENABLE, OUT_ID_LO_ENABLE,
            OUT_ID_PC_PLUS8_INSTR, OUT_ID_UB_INSTR, OUT_ID_JALR_JR_INSTR,
            OUT_ID_MEM_ENABLE, OUT_ID_MEM_READWRITE, OUT_ID_MEM_SIGNE} = out_id_d;

    assign {EX_ALU_OP, EX_OP_H_S, EX_DESTINATION_REGISTER, EX_MEM_SIZE, EX_LOAD_INSTR,
            EX_RF_ENABLE, EX_HI_ENABLE, EX_LO_ENABLE, EX_PC_PLUS8_INSTR, EX_UB_INSTR,
            EX_JALR_JR_INSTR, EX_MEM_ENABLE, EX_MEM_READWRITE, EX_MEM_SIGNE} = ex_q;

endmodule

// File: tb/tb_id_control_unit.sv
// Bench for id_control_unit: directed ISA cases plus randomized instruction streams
// checked against a mnemonic-level reference model.
module tb_id_control_unit;

    typedef struct packed {
        logic [3:0] alu;
        logic [2:0] ophs;
        logic [1:0] dest;
        logic [1:0] size;
        logic load, rf, hi, lo, pc8, ub, jr, men, mrw, msg;
    } ctrl_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] instruction = 32'd0;
    logic        controlMux = 1'b0;
    logic [8:0]  nPC = 9'd0;
    logic [31:0] TA = 32'd0;
    logic        S = 1'b0;
    logic [31:0] Address;

    logic [3:0] ID_ALU_OP, OUT_ID_ALU_OP, EX_ALU_OP;
    logic [2:0] ID_OP_H_S, OUT_ID_OP_H_S, EX_OP_H_S;
    logic [1:0] ID_DESTINATION_REGISTER, OUT_ID_DESTINATION_REGISTER, EX_DESTINATION_REGISTER;
    logic [1:0] ID_MEM_SIZE, OUT_ID_MEM_SIZE, EX_MEM_SIZE;
    logic ID_LOAD_INSTR, ID_RF_ENABLE, ID_HI_ENABLE, ID_LO_ENABLE, ID_PC_PLUS8_INSTR;
    logic ID_UB_INSTR, ID_JALR_JR_INSTR, ID_MEM_ENABLE, ID_MEM_READWRITE, ID_MEM_SIGNE;
    logic OUT_ID_LOAD_INSTR, OUT_ID_RF_ENABLE, OUT_ID_HI_ENABLE, OUT_ID_LO_ENABLE, OUT_ID_PC_PLUS8_INSTR;
    logic OUT_ID_UB_INSTR, OUT_ID_JALR_JR_INSTR, OUT_ID_MEM_ENABLE, OUT_ID_MEM_READWRITE, OUT_ID_MEM_SIGNE;
    logic EX_LOAD_INSTR, EX_RF_ENABLE, EX_HI_ENABLE, EX_LO_ENABLE, EX_PC_PLUS8_INSTR;
    logic EX_UB_INSTR, EX_JALR_JR_INSTR, EX_MEM_ENABLE, EX_MEM_READWRITE, EX_MEM_SIGNE;

    int tests_run = 0;
    int tests_failed = 0;

    ctrl_t id_v, out_v, ex_v;
    assign id_v = {ID_ALU_OP, ID_OP_H_S, ID_DESTINATION_REGISTER, ID_MEM_SIZE, ID_LOAD_INSTR,
                   ID_RF_ENABLE, ID_HI_ENABLE, ID_LO_ENABLE, ID_PC_PLUS8_INSTR, ID_UB_INSTR,
                   ID_JALR_JR_INSTR, ID_MEM_ENABLE, ID_MEM_READWRITE, ID_MEM_SIGNE};
    assign out_v = {OUT_ID_ALU_OP, OUT_ID_OP_H_S, OUT_ID_DESTINATION_REGISTER, OUT_ID_MEM_SIZE,
                    OUT_ID_LOAD_INSTR, OUT_ID_RF_ENABLE, OUT_ID_HI_ENABLE, OUT_ID_LO_ENABLE,
                    OUT_ID_PC_PLUS8_INSTR, OUT_ID_UB_INSTR, OUT_ID_JALR_JR_INSTR,
                    OUT_ID_MEM_ENABLE, OUT_ID_MEM_READWRITE, OUT_ID_MEM_SIGNE};
    assign ex_v = {EX_ALU_OP, EX_OP_H_S, EX_DESTINATION_REGISTER, EX_MEM_SIZE, EX_LOAD_INSTR,
                   EX_RF_ENABLE, EX_HI_ENABLE, EX_LO_ENABLE, EX_PC_PLUS8_INSTR, EX_UB_INSTR,
                   EX_JALR_JR_INSTR, EX_MEM_ENABLE, EX_MEM_READWRITE, EX_MEM_SIGNE};

    id_control_unit dut (
        .Clk(Clk), .Reset(Reset), .instruction(instruction), .controlMux(controlMux),
        .nPC(nPC), .TA(TA), .S(S), .Address(Address),
        .ID_ALU_OP(ID_ALU_OP), .ID_OP_H_S(ID_OP_H_S), .ID_DESTINATION_REGISTER(ID_DESTINATION_REGISTER),
        .ID_MEM_SIZE(ID_MEM_SIZE), .ID_LOAD_INSTR(ID_LOAD_INSTR), .ID_RF_ENABLE(ID_RF_ENABLE),
        .ID_HI_ENABLE(ID_HI_ENABLE), .ID_LO_ENABLE(ID_LO_ENABLE), .ID_PC_PLUS8_INSTR(ID_PC_PLUS8_INSTR),
        .ID_UB_INSTR(ID_UB_INSTR), .ID_JALR_JR_INSTR(ID_JALR_JR_INSTR), .ID_MEM_ENABLE(ID_MEM_ENABLE),
        .ID_MEM_READWRITE(ID_MEM_READWRITE), .ID_MEM_SIGNE(ID_MEM_SIGNE),
        .OUT_ID_ALU_OP(OUT_ID_ALU_OP), .OUT_ID_OP_H_S(OUT_ID_OP_H_S),
        .OUT_ID_DESTINATION_REGISTER(OUT_ID_DESTINATION_REGISTER), .OUT_ID_MEM_SIZE(OUT_ID_MEM_SIZE),
        .OUT_ID_LOAD_INSTR(OUT_ID_LOAD_INSTR), .OUT_ID_RF_ENABLE(OUT_ID_RF_ENABLE),
        .OUT_ID_HI_ENABLE(OUT_ID_HI_ENABLE), .OUT_ID_LO_ENABLE(OUT_ID_LO_ENABLE),
        .OUT_ID_PC_PLUS8_INSTR(OUT_ID_PC_PLUS8_INSTR), .OUT_ID_UB_INSTR(OUT_ID_UB_INSTR),
        .OUT_ID_JALR_JR_INSTR(OUT_ID_JALR_JR_INSTR), .OUT_ID_MEM_ENABLE(OUT_ID_MEM_ENABLE),
        .OUT_ID_MEM_READWRITE(OUT_ID_MEM_READWRITE), .OUT_ID_MEM_SIGNE(OUT_ID_MEM_SIGNE),
        .EX_ALU_OP(EX_ALU_OP), .EX_OP_H_S(EX_OP_H_S), .EX_DESTINATION_REGISTER(EX_DESTINATION_REGISTER),
        .EX_MEM_SIZE(EX_MEM_SIZE), .EX_LOAD_INSTR(EX_LOAD_INSTR), .EX_RF_ENABLE(EX_RF_ENABLE),
        .EX_HI_ENABLE(EX_HI_ENABLE), .EX_LO_ENABLE(EX_LO_ENABLE), .EX_PC_PLUS8_INSTR(EX_PC_PLUS8_INSTR),
        .EX_UB_INSTR(EX_UB_INSTR), .EX_JALR_JR_INSTR(EX_JALR_JR_INSTR), .EX_MEM_ENABLE(EX_MEM_ENABLE),
        .EX_MEM_READWRITE(EX_MEM_READWRITE), .EX_MEM_SIGNE(EX_MEM_SIGNE)
    );

    always #5 Clk = ~Clk;

    // Reference model: name the instruction from the ISA tables, then apply the control rules.
    function automatic string mnem(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        op = ins[31:26];
        fn = ins[5:0];
        rt = ins[20:16];
        if (ins == 32'd0) return "NOP";
        case (op)
            6'h00: case (fn)
                6'h00: return "SLL";   6'h02: return "SRL";   6'h03: return "SRA";
                6'h04: return "SLLV";  6'h06: return "SRLV";  6'h07: return "SRAV";
                6'h08: return "JR";    6'h09: return "JALR";
                6'h10: return "MFHI";  6'h11: return "MTHI";  6'h12: return "MFLO";  6'h13: return "MTLO";
                6'h20: return "ADD";   6'h21: return "ADDU";  6'h22: return "SUB";   6'h23: return "SUBU";
                6'h24: return "AND";   6'h25: return "OR";    6'h26: return "XOR";   6'h27: return "NOR";
                6'h2A: return "SLT";   6'h2B: return "SLTU";
                default: return "UNDEF";
            endcase
            6'h01: case (rt)
                5'd0: return "BLTZ";   5'd1: return "BGEZ";
                5'd16: return "BLTZAL"; 5'd17: return "BGEZAL";
                default: return "UNDEF";
            endcase
            6'h02: return "J";     6'h03: return "JAL";
            6'h04: return "BEQ";   6'h05: return "BNE";   6'h06: return "BLEZ";  6'h07: return "BGTZ";
            6'h08: return "ADDI";  6'h09: return "ADDIU"; 6'h0A: return "SLTI";  6'h0B: return "SLTIU";
            6'h0C: return "ANDI";  6'h0D: return "ORI";   6'h0E: return "XORI";  6'h0F: return "LUI";
            6'h20: return "LB";    6'h21: return "LH";    6'h23: return "LW";
            6'h24: return "LBU";   6'h25: return "LHU";
            6'h28: return "SB";    6'h29: return "SH";    6'h2B: return "SW";
            default: return "UNDEF";
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input string m);
        if (m == "ADD" || m == "ADDU" || m == "ADDI" || m == "ADDIU") return 4'd0;
        if (m == "SUB" || m == "SUBU") return 4'd1;
        if (m == "AND" || m == "ANDI") return 4'd2;
        if (m == "OR" || m == "ORI") return 4'd3;
        if (m == "XOR" || m == "XORI") return 4'd4;
        if (m == "NOR") return 4'd5;
        if (m == "SLL" || m == "SLLV") return 4'd6;
        if (m == "SRL" || m == "SRLV") return 4'd7;
        if (m == "SRA" || m == "SRAV") return 4'd8;
        if (m == "SLT" || m == "SLTI") return 4'd9;
        if (m == "SLTU" || m == "SLTIU") return 4'd10;
        return 4'd15;
    endfunction

    function automatic ctrl_t model(input logic [31:0] ins);
        string m;
        ctrl_t c;
        m = mnem(ins);
        c = '0;
        if (m == "ADD" || m == "ADDU" || m == "SUB" || m == "SUBU" || m == "AND" || m == "OR" ||
            m == "XOR" || m == "NOR" || m == "SLT" || m == "SLTU" || m == "SLLV" || m == "SRLV" || m == "SRAV") begin
            c.alu = alu_of(m); c.rf = 1'b1;
        end else if (m == "SLL" || m == "SRL" || m == "SRA") begin
            c.alu = alu_of(m); c.ophs = 3'd4; c.rf = 1'b1;
        end else if (m == "MFHI" || m == "MFLO") begin
            c.alu = 4'd11; c.ophs = (m == "MFHI") ? 3'd5 : 3'd6; c.rf = 1'b1;
        end else if (m == "MTHI") begin
            c.alu = 4'd12; c.hi = 1'b1;
        end else if (m == "MTLO") begin
            c.alu = 4'd12; c.lo = 1'b1;
        end else if (m == "JR") begin
            c.jr = 1'b1;
        end else if (m == "JALR") begin
            c.jr = 1'b1; c.pc8 = 1'b1; c.rf = 1'b1; c.alu = 4'd11; c.ophs = 3'd7;
        end else if (m == "ADDI" || m == "ADDIU" || m == "SLTI" || m == "SLTIU") begin
            c.alu = alu_of(m); c.ophs = 3'd1; c.rf = 1'b1; c.dest = 2'd1;
        end else if (m == "ANDI" || m == "ORI" || m == "XORI") begin
            c.alu = alu_of(m); c.ophs = 3'd2; c.rf = 1'b1; c.dest = 2'd1;
        end else if (m == "LUI") begin
            c.alu = 4'd11; c.ophs = 3'd3; c.rf = 1'b1; c.dest = 2'd1;
        end else if (m == "LB" || m == "LBU" || m == "LH" || m == "LHU" || m == "LW") begin
            c.load = 1'b1; c.rf = 1'b1; c.dest = 2'd1; c.ophs = 3'd1; c.men = 1'b1;
            c.size = (m[1] == "B") ? 2'd0 : (m[1] == "H") ? 2'd1 : 2'd2;
            c.msg = (m == "LB" || m == "LH");
        end else if (m == "SB" || m == "SH" || m == "SW") begin
            c.men = 1'b1; c.mrw = 1'b1; c.ophs = 3'd1;
            c.size = (m == "SB") ? 2'd0 : (m == "SH") ? 2'd1 : 2'd2;
        end else if (m == "BEQ" || m == "BNE" || m == "BLEZ" || m == "BGTZ" || m == "BLTZ" || m == "BGEZ") begin
            c.alu = 4'd1;
        end else if (m == "BLTZAL" || m == "BGEZAL" || m == "JAL") begin
            c.pc8 = 1'b1; c.rf = 1'b1; c.dest = 2'd2; c.alu = 4'd11; c.ophs = 3'd7;
            c.ub = (m == "JAL");
        end else if (m == "J") begin
            c.ub = 1'b1;
        end
        return c;
    endfunction

    task automatic test_reset();
        ctrl_t exp;
        @(negedge Clk);
        Reset = 1'b1; controlMux = 1'b0; instruction = 32'h8C22_0004;
        @(posedge Clk); #1;
        tests_run++;
        if (ex_v !== ctrl_t'(21'd0)) begin
            tests_failed++; $display("FAIL reset_ex: got %h expected 000000", ex_v);
        end
        exp = model(32'h8C22_0004);
        tests_run++;
        if (id_v !== exp) begin
            tests_failed++; $display("FAIL reset_id_comb: got %h expected %h", id_v, exp);
        end
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk); #1;
        tests_run++;
        if (EX_LOAD_INSTR !== 1'b1 || EX_MEM_SIZE !== 2'b10 || EX_DESTINATION_REGISTER !== 2'b01) begin
            tests_failed++;
            $display("FAIL lw_after_reset: got load=%b size=%b dest=%b expected 1 10 01",
                     EX_LOAD_INSTR, EX_MEM_SIZE, EX_DESTINATION_REGISTER);
        end
        tests_run++;
        if (ex_v !== exp) begin
            tests_failed++; $display("FAIL lw_ex_vector: got %h expected %h", ex_v, exp);
        end
    endtask

    task automatic test_nop_mux();
        @(negedge Clk);
        instruction = 32'h0043_0820; controlMux = 1'b0; #1;
        tests_run++;
        if (ID_ALU_OP !== 4'd0 || ID_RF_ENABLE !== 1'b1 || ID_DESTINATION_REGISTER !== 2'b00 || out_v !== id_v) begin
            tests_failed++;
            $display("FAIL add_decode: got alu=%0d rf=%b dest=%b out=%h expected 0 1 00 %h",
                     ID_ALU_OP, ID_RF_ENABLE, ID_DESTINATION_REGISTER, out_v, id_v);
        end
        controlMux = 1'b1; #1;
        tests_run++;
        if (out_v !== ctrl_t'(21'd0) || id_v !== model(32'h0043_0820)) begin
            tests_failed++; $display("FAIL nop_mux_out: got out=%h id=%h expected out 000000", out_v, id_v);
        end
        @(posedge Clk); #1;
        tests_run++;
        if (ex_v !== ctrl_t'(21'd0)) begin
            tests_failed++; $display("FAIL nop_mux_ex: got %h expected 000000", ex_v);
        end
        controlMux = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] words [7];
        words = '{32'hA022_0003, 32'h8022_0003, 32'h9022_0003, 32'h0C00_0010,
                  32'h03E0_0008, 32'h0000_0000, 32'hFC00_0000};
        foreach (words[k]) begin
            @(negedge Clk);
            instruction = words[k]; controlMux = 1'b0; #1;
            tests_run++;
            if (id_v !== model(words[k])) begin
                tests_failed++; $display("FAIL directed_%h: got %h expected %h", words[k], id_v, model(words[k]));
            end
        end
        // Spot checks of individual fields against hand-written values
        @(negedge Clk); instruction = 32'hA022_0003; #1;
        tests_run++;
        if (ID_MEM_ENABLE !== 1'b1 || ID_MEM_READWRITE !== 1'b1 || ID_MEM_SIZE !== 2'b00 || ID_RF_ENABLE !== 1'b0) begin
            tests_failed++; $display("FAIL sb_fields: got %b%b%b%b expected 11000", ID_MEM_ENABLE, ID_MEM_READWRITE, ID_MEM_SIZE, ID_RF_ENABLE);
        end
        instruction = 32'h8022_0003; #1;
        tests_run++;
        if (ID_MEM_SIGNE !== 1'b1) begin tests_failed++; $display("FAIL lb_signe: got %b expected 1", ID_MEM_SIGNE); end
        instruction = 32'h9022_0003; #1;
        tests_run++;
        if (ID_MEM_SIGNE !== 1'b0) begin tests_failed++; $display("FAIL lbu_signe: got %b expected 0", ID_MEM_SIGNE); end
        instruction = 32'h0C00_0010; #1;
        tests_run++;
        if (ID_UB_INSTR !== 1'b1 || ID_PC_PLUS8_INSTR !== 1'b1 || ID_DESTINATION_REGISTER !== 2'b10) begin
            tests_failed++; $display("FAIL jal_fields: got ub=%b pc8=%b dest=%b expected 1 1 10", ID_UB_INSTR, ID_PC_PLUS8_INSTR, ID_DESTINATION_REGISTER);
        end
        instruction = 32'h03E0_0008; #1;
        tests_run++;
        if (ID_JALR_JR_INSTR !== 1'b1 || ID_RF_ENABLE !== 1'b0) begin
            tests_failed++; $display("FAIL jr_fields: got jr=%b rf=%b expected 1 0", ID_JALR_JR_INSTR, ID_RF_ENABLE);
        end
        instruction = 32'hFC00_0000; #1;
        tests_run++;
        if (id_v !== ctrl_t'(21'd0)) begin tests_failed++; $display("FAIL undef_op: got %h expected 000000", id_v); end
        instruction = 32'h0000_0000; #1;
        tests_run++;
        if (id_v !== ctrl_t'(21'd0)) begin tests_failed++; $display("FAIL zero_word: got %h expected 000000", id_v); end
    endtask

    task automatic test_address();
        @(negedge Clk);
        nPC = 9'h1FC; TA = 32'h0000_0040; S = 1'b0; #1;
        tests_run++;
        if (Address !== 32'h0000_01FC) begin tests_failed++; $display("FAIL addr_npc: got %h expected 000001fc", Address); end
        S = 1'b1; #1;
        tests_run++;
        if (Address !== 32'h0000_0040) begin tests_failed++; $display("FAIL addr_ta: got %h expected 00000040", Address); end
        for (int i = 0; i < 20; i++) begin
            nPC = 9'($urandom); TA = $urandom; S = 1'($urandom); #1;
            tests_run++;
            if (Address !== (S ? TA : 32'(nPC))) begin
                tests_failed++; $display("FAIL addr_rand: got %h expected %h", Address, (S ? TA : 32'(nPC)));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [26];
        logic [5:0] fns [22];
        ctrl_t exp;
        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00, 6'h01};
        fns = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h10, 6'h11, 6'h12,
                6'h13, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        for (int i = 0; i < 400; i++) begin
            @(negedge Clk);
            instruction = $urandom;
            if ($urandom_range(0, 3) != 0) instruction[31:26] = ops[$urandom_range(0, 25)];
            if (instruction[31:26] == 6'h00 && $urandom_range(0, 3) != 0) instruction[5:0] = fns[$urandom_range(0, 21)];
            if (instruction[31:26] == 6'h01 && $urandom_range(0, 1) != 0)
                instruction[20:16] = 5'($urandom_range(0, 1)) | ($urandom_range(0, 1) != 0 ? 5'd16 : 5'd0);
            controlMux = ($urandom_range(0, 4) == 0);
            #1;
            exp = model(instruction);
            tests_run++;
            if (id_v !== exp) begin
                tests_failed++; $display("FAIL rand_id[%0d] ins=%h: got %h expected %h", i, instruction, id_v, exp);
            end
            tests_run++;
            if (out_v !== (controlMux ? ctrl_t'(21'd0) : exp)) begin
                tests_failed++; $display("FAIL rand_out[%0d] ins=%h: got %h expected %h", i, instruction, out_v, (controlMux ? ctrl_t'(21'd0) : exp));
            end
            @(posedge Clk); #1;
            tests_run++;
            if (ex_v !== (controlMux ? ctrl_t'(21'd0) : exp)) begin
                tests_failed++; $display("FAIL rand_ex[%0d] ins=%h: got %h expected %h", i, instruction, ex_v, (controlMux ? ctrl_t'(21'd0) : exp));
            end
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge Clk);
        Reset = 1'b0; controlMux = 1'b0; instruction = 32'h0043_0820;
        @(negedge Clk);
        Reset = 1'b1; instruction = 32'h8C22_0004;
        @(posedge Clk); #1;
        tests_run++;
        if (ex_v !== ctrl_t'(21'd0)) begin tests_failed++; $display("FAIL reset_mid: got %h expected 000000", ex_v); end
        @(negedge Clk);
        controlMux = 1'b1; instruction = 32'h0C00_0010;
        @(posedge Clk); #1;
        tests_run++;
        if (ex_v !== ctrl_t'(21'd0) || id_v !== model(32'h0C00_0010)) begin
            tests_failed++; $display("FAIL reset_and_nop: got ex=%h id=%h expected ex 000000", ex_v, id_v);
        end
        @(negedge Clk);
        Reset = 1'b0; controlMux = 1'b0;
        @(posedge Clk); #1;
        tests_run++;
        if (ex_v !== model(32'h0C00_0010)) begin
            tests_failed++; $display("FAIL jal_after_reset: got %h expected %h", ex_v, model(32'h0C00_0010));
        end
    endtask

    initial begin
        test_reset();
        test_nop_mux();
        test_directed();
        test_address();
        test_back_to_back();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
